// File: rtl/branch_pred_unit_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pred_unit_pkg;

  // Branch kinds as decoded by the core; kept here so decode and predictor agree.
  typedef enum logic [2:0] {
    BR_JAL  = 3'd0,
    BR_JALR = 3'd1,
    BR_EQ   = 3'd2,
    BR_NE   = 3'd3,
    BR_LT   = 3'd4,
    BR_GE   = 3'd5
  } br_type_e;

  // Instructions are word aligned, so the index starts above the byte offset.
  localparam int unsigned IDX_LSB = 2;

  function automatic int unsigned idx_msb(input int unsigned idx_bits);
    return IDX_LSB + idx_bits - 1;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned idx_bits);
    return IDX_LSB + idx_bits;
  endfunction

  function automatic int unsigned tag_msb(input int unsigned idx_bits, input int unsigned tag_bits);
    return IDX_LSB + idx_bits + tag_bits - 1;
  endfunction

  // Weakly not-taken: the value just below the taken threshold (MSB set).
  function automatic logic [3:0] ctr_reset_val(input int unsigned ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/branch_pred_unit_ras.sv
// Circular return address stack; a push on a full stack drops the oldest entry.
// Latency: top_o is combinational from state; push/pop take effect on the falling clock edge.
// Backpressure: none; pop on empty is ignored, push on full overwrites.
module ras_stack
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [31:0]   data_i,
  output logic [31:0]   top_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d, wr_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [31:0]   mem_q [DEPTH];
  logic          empty;

  assign empty   = (cnt_q == '0);
  assign top_o   = mem_q[ptr_q - PW'(1)];
  assign count_o = cnt_q;

  // Next pointer/count and write slot; call+return replaces the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (push_i && pop_i && !empty) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_q - PW'(1);
    end else if (push_i) begin
      wr_en  = 1'b1;
      ptr_d  = ptr_q + PW'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(negedge clock) begin
    if (wr_en) mem_q[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch predictor: saturating-counter BHT, tagged BTB and return address stack.
// Latency: lookup is combinational; updates land on the falling clock edge, visible next cycle.
// Backpressure: none; every update and lookup is accepted each cycle.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 9,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned TAG_BITS  = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] lk_pc,
  input  logic        lk_valid,
  input  logic        lk_is_branch,
  input  logic        lk_is_call,
  input  logic        lk_is_ret,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispreds
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int unsigned I_MSB = idx_msb(IDX_BITS);
  localparam int unsigned T_LSB = tag_lsb(IDX_BITS);
  localparam int unsigned T_MSB = tag_msb(IDX_BITS, TAG_BITS);
  localparam int unsigned RCW = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] ctr_q     [ENTRIES];
  logic [ENTRIES-1:0]  btb_vld_q;
  logic [TAG_BITS-1:0] btb_tag_q [ENTRIES];
  logic [31:0]         btb_tgt_q [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0] lk_tag, upd_tag;
  logic [31:0]         lk_seq;
  logic                btb_hit;
  logic [CTR_BITS-1:0] ctr_upd_d;
  logic [31:0]         lookups_q, lookups_d;
  logic [31:0]         mispreds_q, mispreds_d;
  logic [31:0]         ras_top;
  logic [RCW-1:0]      ras_count;
  logic                unused_pc_bits;

  assign lk_idx  = lk_pc[I_MSB:IDX_LSB];
  assign lk_tag  = lk_pc[T_MSB:T_LSB];
  assign upd_idx = upd_pc[I_MSB:IDX_LSB];
  assign upd_tag = upd_pc[T_MSB:T_LSB];
  assign lk_seq  = lk_pc + 32'd4;
  assign btb_hit = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  // Byte offset and bits above the tag do not take part in indexing.
  assign unused_pc_bits = ^{lk_pc, upd_pc};

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock   (clock),
    .reset   (reset),
    .push_i  (lk_valid && lk_is_call),
    .pop_i   (lk_valid && lk_is_ret),
    .data_i  (lk_seq),
    .top_o   (ras_top),
    .count_o (ras_count)
  );

  // Combinational prediction from pre-update state; forced to fall-through in reset.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = lk_seq;
    if (!reset && lk_valid) begin
      if (lk_is_branch) begin
        if (ctr_q[lk_idx][CTR_BITS-1] && btb_hit) begin
          pred_taken  = 1'b1;
          pred_target = btb_tgt_q[lk_idx];
        end
      end else if (lk_is_ret) begin
        if (ras_count != '0) begin
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end
      end
    end
  end

  // Saturating next value for the counter being trained.
  always_comb begin
    ctr_upd_d = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != CTR_MAX) ctr_upd_d = ctr_q[upd_idx] + CTR_BITS'(1);
    end else if (ctr_q[upd_idx] != '0) begin
      ctr_upd_d = ctr_q[upd_idx] - CTR_BITS'(1);
    end
  end

  // Counter table: all entries return to weakly not-taken on reset.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= ctr_upd_d;
    end
  end

  // BTB valid bits; a taken branch claims its slot regardless of any alias.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      btb_vld_q <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_vld_q[upd_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload, qualified by the valid bits so left unreset.
  always_ff @(negedge clock) begin
    if (upd_valid && upd_taken) begin
      btb_tag_q[upd_idx] <= upd_tag;
      btb_tgt_q[upd_idx] <= upd_target;
    end
  end

  // Statistic increments; both wrap naturally at 2**32.
  always_comb begin
    lookups_d  = lookups_q;
    mispreds_d = mispreds_q;
    if (lk_valid && (lk_is_branch || lk_is_ret)) lookups_d = lookups_q + 32'd1;
    if (upd_valid && upd_mispred) mispreds_d = mispreds_q + 32'd1;
  end

  // Statistic registers.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      lookups_q  <= '0;
      mispreds_q <= '0;
    end else begin
      lookups_q  <= lookups_d;
      mispreds_q <= mispreds_d;
    end
  end

  assign stat_lookups  = lookups_q;
  assign stat_mispreds = mispreds_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed and random checks of branch_pred_unit against a queue/array reference model.
// Inputs change just after the rising edge; state moves on the falling edge.
// Outputs are sampled 1-2 ns after the rising edge, well clear of the falling edge.
module tb_branch_pred_unit;

  localparam int IDX_BITS  = 9;
  localparam int CTR_BITS  = 2;
  localparam int TAG_BITS  = 8;
  localparam int RAS_DEPTH = 4;
  localparam int ENTRIES   = 1 << IDX_BITS;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] lk_pc;
  logic        lk_valid, lk_is_branch, lk_is_call, lk_is_ret;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] stat_lookups, stat_mispreds;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ctr [ENTRIES];
  bit          m_bv  [ENTRIES];
  int unsigned m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  logic [31:0] m_ras [$];
  logic [31:0] m_lk, m_mis;

  always #5 clock = ~clock;

  branch_pred_unit #(
    .IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS), .TAG_BITS(TAG_BITS), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .lk_pc(lk_pc), .lk_valid(lk_valid), .lk_is_branch(lk_is_branch),
    .lk_is_call(lk_is_call), .lk_is_ret(lk_is_ret),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .stat_lookups(stat_lookups), .stat_mispreds(stat_mispreds)
  );

  function automatic int pidx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned ptag(input logic [31:0] pc);
    return (pc >> (IDX_BITS + 2)) % (1 << TAG_BITS);
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic lit(input string nm, input bit t, input logic [31:0] tg);
    chk({nm, ".taken"}, 32'(pred_taken), 32'(t));
    chk({nm, ".target"}, pred_target, tg);
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_ctr[i] = (1 << (CTR_BITS - 1)) - 1;
      m_bv[i]  = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = '0;
    end
    m_ras.delete();
    m_lk  = '0;
    m_mis = '0;
  endtask

  task automatic model_predict(output bit t, output logic [31:0] tg);
    int i;
    t  = 1'b0;
    tg = lk_pc + 32'd4;
    i  = pidx(lk_pc);
    if (lk_valid && lk_is_branch) begin
      if (m_ctr[i] >= (1 << (CTR_BITS - 1)) && m_bv[i] && m_tag[i] == ptag(lk_pc)) begin
        t  = 1'b1;
        tg = m_tgt[i];
      end
    end else if (lk_valid && lk_is_ret && m_ras.size() > 0) begin
      t  = 1'b1;
      tg = m_ras[$];
    end
  endtask

  task automatic model_update();
    int i;
    if (upd_valid) begin
      i = pidx(upd_pc);
      if (upd_taken) begin
        if (m_ctr[i] < (1 << CTR_BITS) - 1) m_ctr[i]++;
        m_bv[i]  = 1'b1;
        m_tag[i] = ptag(upd_pc);
        m_tgt[i] = upd_target;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
      if (upd_mispred) m_mis++;
    end
    if (lk_valid && (lk_is_branch || lk_is_ret)) m_lk++;
    if (lk_valid) begin
      if (lk_is_call && lk_is_ret && m_ras.size() > 0) begin
        m_ras[m_ras.size() - 1] = lk_pc + 32'd4;
      end else if (lk_is_call) begin
        m_ras.push_back(lk_pc + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (lk_is_ret && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic set_lk(input bit v, input bit br, input bit call, input bit ret, input logic [31:0] pc);
    lk_valid = v; lk_is_branch = br; lk_is_call = call; lk_is_ret = ret; lk_pc = pc;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit t, input logic [31:0] tg, input bit mis);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tg; upd_mispred = mis;
  endtask

  // One cycle: compare against the model, let the falling edge commit, advance the model.
  task automatic step(input string nm);
    bit          et;
    logic [31:0] eg;
    #1;
    model_predict(et, eg);
    chk({nm, ".taken"}, 32'(pred_taken), 32'(et));
    chk({nm, ".target"}, pred_target, eg);
    chk({nm, ".lookups"}, stat_lookups, m_lk);
    chk({nm, ".mispreds"}, stat_mispreds, m_mis);
    @(negedge clock);
    model_update();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_lk(0, 0, 0, 0, 32'h0);
    set_upd(0, 32'h0, 0, 32'h0, 0);
    model_reset();

    // Outputs while held in reset
    @(posedge clock); #1;
    set_lk(1, 1, 0, 0, 32'h100);
    #1;
    lit("in_reset", 0, 32'h104);
    chk("in_reset.lookups", stat_lookups, 32'h0);
    chk("in_reset.mispreds", stat_mispreds, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    lit("post_reset", 0, 32'h104);
    step("post_reset");

    // Counter saturation and decay at 0x100
    set_upd(1, 32'h100, 1, 32'h40, 0);
    step("sat_t1");
    lit("sat_after_t1", 1, 32'h40);
    step("sat_t2");
    step("sat_t3");
    lit("sat_after_t3", 1, 32'h40);
    set_upd(1, 32'h100, 0, 32'h40, 1);
    step("sat_nt1");
    lit("sat_after_nt1", 1, 32'h40);
    step("sat_nt2");
    lit("sat_after_nt2", 0, 32'h104);

    // BTB alias: same index, different tag
    set_upd(1, 32'h100, 1, 32'h40, 0);
    step("alias_train");
    set_upd(0, 32'h0, 0, 32'h0, 0);
    set_lk(1, 1, 0, 0, 32'h100 + (32'h1 << (IDX_BITS + 2)));
    #1;
    lit("alias_miss", 0, 32'h904);
    step("alias_miss");
    set_lk(1, 1, 0, 0, 32'h100);
    #1;
    lit("alias_home", 1, 32'h40);
    step("alias_home");

    // RAS: five calls into a depth-4 stack, then five returns
    for (int k = 1; k <= 5; k++) begin
      set_lk(1, 0, 1, 0, 32'(k * 16));
      step("ras_call");
    end
    for (int k = 0; k < 5; k++) begin
      set_lk(1, 0, 0, 1, 32'h80);
      #1;
      if (k < 4) lit("ras_ret", 1, 32'h54 - 32'(k * 16));
      else       lit("ras_ret_empty", 0, 32'h84);
      step("ras_ret");
    end

    // Same-edge update and lookup at 0x200
    set_lk(1, 1, 0, 0, 32'h200);
    set_upd(1, 32'h200, 1, 32'h300, 0);
    #1;
    lit("same_edge_pre", 0, 32'h204);
    step("same_edge");
    set_upd(0, 32'h0, 0, 32'h0, 0);
    lit("same_edge_post", 1, 32'h300);

    // Reset mid-stream after training and pushes
    for (int k = 0; k < 3; k++) begin
      set_lk(1, 0, 1, 0, 32'h500 + 32'(k * 4));
      set_upd(1, 32'h600, 1, 32'h700, 1);
      step("pre_rst");
    end
    reset = 1'b1;
    model_reset();
    set_lk(1, 1, 0, 0, 32'h600);
    #1;
    lit("mid_rst_br", 0, 32'h604);
    chk("mid_rst.lookups", stat_lookups, 32'h0);
    chk("mid_rst.mispreds", stat_mispreds, 32'h0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    set_upd(0, 32'h0, 0, 32'h0, 0);
    set_lk(1, 0, 0, 1, 32'h90);
    #1;
    lit("post_rst_ret", 0, 32'h94);
    step("post_rst_ret");
    set_lk(1, 1, 0, 0, 32'h600);
    #1;
    lit("post_rst_br", 0, 32'h604);
    step("post_rst_br");

    // Random traffic over a small pc pool so hits, aliases and RAS wraps occur
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pl, pu;
      int unsigned kind;
      pl   = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 11);
      pu   = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 11);
      kind = $urandom_range(0, 5);
      set_lk($urandom_range(0, 5) != 0, kind == 1 || kind == 2, kind == 3 || kind == 5,
             kind == 4 || kind == 5, pl);
      set_upd($urandom_range(0, 1) == 1, pu, $urandom_range(0, 2) != 0,
              $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Standalone, parametrised branch prediction unit for the pipelined RV32 core.
- Replaces the fixed 512-entry 2-bit table that was embedded in the CPU with three structures:
  - a configurable-width saturating-counter table (BHT);
  - a tagged branch target buffer (BTB);
  - a return address stack (RAS).
- Lookup is combinational from the IF-stage pc and decode flags. Update comes from EX-stage branch resolution. All state changes on the falling edge of clock, matching the pipeline registers.

Parameters:
- IDX_BITS, 9: BHT/BTB index width; entries = 2**IDX_BITS.
- CTR_BITS, 2: saturating counter width, range 1..4.
- TAG_BITS, 8: BTB tag width.
- RAS_DEPTH, 4: return stack entries, power of two, at least 2.

Ports:
- clock  in  1  system clock; state updates on negedge.
- reset  in  1  asynchronous, active-high reset.
- lk_pc  in  32  IF-stage pc.
- lk_valid  in  1  IF instruction not flushed.
- lk_is_branch  in  1  decoded conditional branch.
- lk_is_call  in  1  jal/jalr with rd = x1 or x5.
- lk_is_ret  in  1  jalr, rs1 = x1/x5, rd = x0.
- pred_taken  out  1  predicted redirect.
- pred_target  out  32  predicted next pc.
- upd_valid  in  1  EX resolved a conditional branch (not flushed).
- upd_pc  in  32  pc of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_mispred  in  1  prediction was wrong (statistics only).
- stat_lookups  out  32  count of valid branch/ret lookups.
- stat_mispreds  out  32  count of upd_valid && upd_mispred.

Behaviour:
- Index and tag fields:
  - idx(pc) = pc[IDX_BITS+1:2]; the byte offset is excluded.
  - tag(pc) = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Reset (asynchronous, any time, including mid-update):
  - every counter = 2**(CTR_BITS-1)-1 (weakly not-taken);
  - all BTB valid bits = 0;
  - RAS pointer = 0 and RAS count = 0;
  - stat counters = 0.
  - Outputs during reset are pred_taken = 0 and pred_target = lk_pc+4.
- Lookup (combinational, zero latency):
  - btb_hit = valid[idx] && tag[idx] == tag(lk_pc).
  - Branch case (lk_valid && lk_is_branch): pred_taken = ctr[idx] MSB && btb_hit; pred_target = btb_target[idx] when taken, otherwise lk_pc+4.
  - Return case (lk_valid && lk_is_ret):
    - If RAS count > 0: pred_taken = 1 and pred_target = RAS top.
    - If count = 0: pred_taken = 0 and pred_target = lk_pc+4.
  - Otherwise: pred_taken = 0 and pred_target = lk_pc+4.
- Update (negedge, when upd_valid):
  - Counter: upd_taken increments, saturating at 2**CTR_BITS-1; not taken decrements, saturating at 0.
  - BTB: if upd_taken, write valid = 1, tag(upd_pc) and upd_target, overwriting any alias. Not-taken updates leave the BTB unchanged.
- Same-cycle lookup and update to the same index:
  - the lookup sees pre-update contents;
  - the new value is visible on the next cycle.
- RAS (negedge, gated by lk_valid):
  - Call: push lk_pc+4 at the pointer, pointer+1 mod RAS_DEPTH, count = min(count+1, RAS_DEPTH).
  - Full stack: a push overwrites the oldest entry (circular) and count stays at RAS_DEPTH.
  - Return: pointer-1 mod RAS_DEPTH, count-1. A return with count = 0 is a no-op.
  - Call and return together (jalr x1, x1): pop then push, so the top is replaced by lk_pc+4 and count is unchanged, except that when count = 0 it becomes 1.
  - There is no RAS repair on misprediction.
- Statistics: 32-bit counters that wrap silently at 2**32.
  - stat_lookups counts lk_valid && (lk_is_branch || lk_is_ret).
  - stat_mispreds counts upd_valid && upd_mispred.

Decomposition:
- Shared package holds:
  - branch-type encodings (jal, jalr, eq, ne, lt, ge);
  - the counter reset-value function;
  - idx/tag extraction constants derived from IDX_BITS and TAG_BITS.
- One natural sub-module: ras_stack, parametrised by RAS_DEPTH. It has push/pop/data/top/count ports.
- The BHT and BTB stay inline.

Test Plan:
- Reset, then lookup of a branch at pc 0x100 → pred_taken = 0, pred_target = 0x104. Both stat counters read 0.
- Counter saturation (CTR_BITS = 2), starting from the reset counter value 1:
  - Three taken updates at 0x100 with target 0x40 → a lookup after the first update shows pred_taken = 1, pred_target = 0x40; the counter stays at 3.
  - Then one not-taken update → still predicted taken (counter 2).
  - Then a second not-taken update → pred_taken = 0 (counter 1).
- BTB alias: taken update at 0x100, then lookup at 0x100 + (1 << (IDX_BITS+2)) → same counter entry but tag mismatch, so pred_taken = 0.
- RAS sequence:
  - Calls at 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4), then five returns → predicted targets 0x54, 0x44, 0x34, 0x24.
  - The fifth return gives pred_taken = 0 because count is 0.
- Same-edge update and lookup at 0x200 with counter at 1 and a taken update → the lookup in that cycle gives not-taken; the following cycle gives taken.
- Assert reset mid-stream after several taken updates and RAS pushes → the next lookup at any pc gives pred_taken = 0, the RAS is empty and the stat counters are 0.
